// File: rtl/plate_input_cond.sv
// Key conditioning for plate_render: sync, debounce, press detect, frame-aligned move requests.
// Define PLATE_AUTOREPEAT_EN to add held-key auto-repeat (one request every REPEAT_RATE frames).
module plate_input_cond #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int REPEAT_DELAY    = 20,
    parameter int REPEAT_RATE     = 4
) (
    input  logic       clock,
    input  logic       resetn,
    input  logic       key_left_n,
    input  logic       key_right_n,
    input  logic       draw_done,
    output logic       left_n,
    output logic       right_n,
    output logic [1:0] held
);

    localparam int            CW      = $clog2(DEBOUNCE_CYCLES + 1);
    localparam logic [CW-1:0] DB_LAST = CW'(DEBOUNCE_CYCLES - 1);

    // Bit [1] is left, bit [0] is right throughout.
    logic [1:0]    sync1_q, sync1_d;
    logic [1:0]    sync2_q, sync2_d;
    logic [1:0]    held_q, held_d;
    logic [1:0]    held_dly_q, held_dly_d;
    logic [1:0]    pend_q, pend_d;
    logic [1:0]    armed_q, armed_d;
    logic [CW-1:0] db_cnt_q [2];
    logic [CW-1:0] db_cnt_d [2];
    logic [1:0]    level;
    logic [1:0]    press;
    logic [1:0]    rpt_req;
    logic [1:0]    req;

    always_comb begin
        sync1_d    = {key_left_n, key_right_n};
        sync2_d    = sync1_q;
        level      = ~sync2_q;
        held_d     = held_q;
        held_dly_d = held_q;
        for (int i = 0; i < 2; i++) begin
            db_cnt_d[i] = '0;
            if (level[i] != held_q[i]) begin
                if (db_cnt_q[i] == DB_LAST) begin
                    held_d[i] = ~held_q[i];
                end else begin
                    db_cnt_d[i] = db_cnt_q[i] + CW'(1);
                end
            end
        end
    end

    assign press = held_q & ~held_dly_q;

`ifdef PLATE_AUTOREPEAT_EN
    localparam logic [7:0] RPT_LAST   = 8'(REPEAT_DELAY - 1);
    localparam logic [7:0] RPT_RELOAD = 8'(REPEAT_DELAY - REPEAT_RATE);

    logic [7:0] rpt_cnt_q [2];
    logic [7:0] rpt_cnt_d [2];

    // Counts frame boundaries while held; the request lands in pending on the boundary edge.
    always_comb begin
        rpt_req = 2'b00;
        for (int i = 0; i < 2; i++) begin
            rpt_cnt_d[i] = rpt_cnt_q[i];
            if (!held_q[i] || press[i]) begin
                rpt_cnt_d[i] = 8'd0;
            end else if (draw_done) begin
                if (rpt_cnt_q[i] == RPT_LAST) begin
                    rpt_req[i]   = 1'b1;
                    rpt_cnt_d[i] = RPT_RELOAD;
                end else begin
                    rpt_cnt_d[i] = rpt_cnt_q[i] + 8'd1;
                end
            end
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            rpt_cnt_q[0] <= 8'd0;
            rpt_cnt_q[1] <= 8'd0;
        end else begin
            rpt_cnt_q[0] <= rpt_cnt_d[0];
            rpt_cnt_q[1] <= rpt_cnt_d[1];
        end
    end
`else
    // Repeat timing has no effect without auto-repeat; only press events make requests.
    localparam int RPT_CFG_SUM = REPEAT_DELAY + REPEAT_RATE;
    assign rpt_req = (RPT_CFG_SUM < 0) ? 2'b11 : 2'b00;
`endif

    // Frame boundary: pending moves to armed; simultaneous left+right cancel out.
    always_comb begin
        req = press | rpt_req;
        if (draw_done) begin
            armed_d = (pend_q == 2'b11) ? 2'b00 : pend_q;
            pend_d  = req;
        end else begin
            armed_d = armed_q;
            pend_d  = pend_q | req;
        end
    end

    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            sync1_q     <= 2'b11;
            sync2_q     <= 2'b11;
            held_q      <= 2'b00;
            held_dly_q  <= 2'b00;
            pend_q      <= 2'b00;
            armed_q     <= 2'b00;
            db_cnt_q[0] <= '0;
            db_cnt_q[1] <= '0;
        end else begin
            sync1_q     <= sync1_d;
            sync2_q     <= sync2_d;
            held_q      <= held_d;
            held_dly_q  <= held_dly_d;
            pend_q      <= pend_d;
            armed_q     <= armed_d;
            db_cnt_q[0] <= db_cnt_d[0];
            db_cnt_q[1] <= db_cnt_d[1];
        end
    end

    assign left_n  = ~armed_q[1];
    assign right_n = ~armed_q[0];
    assign held    = held_q;

endmodule

// File: tb/tb_plate_input_cond.sv
// Directed bench for plate_input_cond with DEBOUNCE_CYCLES=4, REPEAT_DELAY=3, REPEAT_RATE=2
// and a draw_done pulse every 100 cycles. Expectations follow PLATE_AUTOREPEAT_EN if defined.
module tb_plate_input_cond;

    logic       clock = 1'b0;
    logic       resetn;
    logic       key_left_n;
    logic       key_right_n;
    logic       draw_done;
    wire        left_n;
    wire        right_n;
    wire  [1:0] held;

    int n_cmp     = 0;
    int n_fail    = 0;
    int frame_cyc = 0;

    plate_input_cond #(
        .DEBOUNCE_CYCLES(4),
        .REPEAT_DELAY   (3),
        .REPEAT_RATE    (2)
    ) dut (
        .clock      (clock),
        .resetn     (resetn),
        .key_left_n (key_left_n),
        .key_right_n(key_right_n),
        .draw_done  (draw_done),
        .left_n     (left_n),
        .right_n    (right_n),
        .held       (held)
    );

    always #5 clock = ~clock;

    // One clock: draw_done is high on the 100th cycle of each frame; sample 1 time unit after the edge.
    task automatic tick();
        draw_done = (frame_cyc == 99);
        @(posedge clock);
        #1;
        draw_done = 1'b0;
        frame_cyc = (frame_cyc == 99) ? 0 : frame_cyc + 1;
    endtask

    task automatic ticks(input int n);
        repeat (n) tick();
    endtask

    // Advance through the next draw_done edge; afterwards outputs show the new frame's armed value.
    task automatic to_boundary();
        do tick(); while (frame_cyc != 0);
    endtask

    task automatic do_reset();
        resetn      = 1'b0;
        key_left_n  = 1'b1;
        key_right_n = 1'b1;
        draw_done   = 1'b0;
        repeat (3) begin
            @(posedge clock);
            #1;
        end
        resetn    = 1'b1;
        frame_cyc = 0;
    endtask

    task automatic test_reset();
        do_reset();
        n_cmp++; if (left_n !== 1'b1) begin n_fail++; $display("FAIL reset_left_n: got %b expected 1", left_n); end
        n_cmp++; if (right_n !== 1'b1) begin n_fail++; $display("FAIL reset_right_n: got %b expected 1", right_n); end
        n_cmp++; if (held !== 2'b00) begin n_fail++; $display("FAIL reset_held: got %b expected 00", held); end
        for (int f = 0; f < 3; f++) begin
            to_boundary();
            n_cmp++; if ({left_n, right_n} !== 2'b11) begin n_fail++; $display("FAIL idle_frame%0d_outs: got %b expected 11", f, {left_n, right_n}); end
            n_cmp++; if (held !== 2'b00) begin n_fail++; $display("FAIL idle_frame%0d_held: got %b expected 00", f, held); end
        end
        key_left_n = 1'b0;
        ticks(10);
        key_left_n = 1'b1;
        to_boundary();
        n_cmp++; if (left_n !== 1'b0) begin n_fail++; $display("FAIL prereset_armed_left_n: got %b expected 0", left_n); end
        ticks(30);
        #2;
        resetn = 1'b0;
        #1;
        n_cmp++; if (left_n !== 1'b1) begin n_fail++; $display("FAIL async_reset_left_n: got %b expected 1", left_n); end
        n_cmp++; if (right_n !== 1'b1) begin n_fail++; $display("FAIL async_reset_right_n: got %b expected 1", right_n); end
        tick();
        resetn = 1'b1;
    endtask

    task automatic test_debounce();
        do_reset();
        key_left_n = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            n_cmp++; if (held !== 2'b00) begin n_fail++; $display("FAIL glitch_low_held%0d: got %b expected 00", i, held); end
        end
        key_left_n = 1'b1;
        for (int i = 0; i < 8; i++) begin
            tick();
            n_cmp++; if (held !== 2'b00) begin n_fail++; $display("FAIL glitch_after_held%0d: got %b expected 00", i, held); end
        end
        to_boundary();
        n_cmp++; if (left_n !== 1'b1) begin n_fail++; $display("FAIL glitch_left_n: got %b expected 1", left_n); end
        key_left_n = 1'b0;
        for (int i = 1; i <= 10; i++) begin
            tick();
            n_cmp++;
            if (held !== ((i >= 6) ? 2'b10 : 2'b00)) begin
                n_fail++;
                $display("FAIL press_held_edge%0d: got %b expected %b", i, held, (i >= 6) ? 2'b10 : 2'b00);
            end
        end
        key_left_n = 1'b1;
        ticks(10);
        n_cmp++; if (left_n !== 1'b1) begin n_fail++; $display("FAIL press_before_boundary_left_n: got %b expected 1", left_n); end
        to_boundary();
        n_cmp++; if (left_n !== 1'b0) begin n_fail++; $display("FAIL press_armed_left_n: got %b expected 0", left_n); end
        n_cmp++; if (right_n !== 1'b1) begin n_fail++; $display("FAIL press_armed_right_n: got %b expected 1", right_n); end
        to_boundary();
        n_cmp++; if (left_n !== 1'b1) begin n_fail++; $display("FAIL press_next_frame_left_n: got %b expected 1", left_n); end
    endtask

    task automatic test_press_at_boundary();
        do_reset();
        ticks(93);
        key_left_n = 1'b0;
        ticks(5);
        n_cmp++; if (held !== 2'b00) begin n_fail++; $display("FAIL edge_press_held_early: got %b expected 00", held); end
        tick();
        n_cmp++; if (held !== 2'b10) begin n_fail++; $display("FAIL edge_press_held_rise: got %b expected 10", held); end
        tick();
        n_cmp++; if (left_n !== 1'b1) begin n_fail++; $display("FAIL edge_press_same_boundary_left_n: got %b expected 1", left_n); end
        ticks(3);
        key_left_n = 1'b1;
        ticks(20);
        n_cmp++; if (left_n !== 1'b1) begin n_fail++; $display("FAIL edge_press_mid_frame_left_n: got %b expected 1", left_n); end
        to_boundary();
        n_cmp++; if (left_n !== 1'b0) begin n_fail++; $display("FAIL edge_press_next_boundary_left_n: got %b expected 0", left_n); end
        to_boundary();
        n_cmp++; if (left_n !== 1'b1) begin n_fail++; $display("FAIL edge_press_after_left_n: got %b expected 1", left_n); end
    endtask

    task automatic test_both_pending();
        do_reset();
        key_left_n  = 1'b0;
        key_right_n = 1'b0;
        ticks(10);
        n_cmp++; if (held !== 2'b11) begin n_fail++; $display("FAIL both_held: got %b expected 11", held); end
        key_left_n  = 1'b1;
        key_right_n = 1'b1;
        ticks(10);
        to_boundary();
        n_cmp++; if ({left_n, right_n} !== 2'b11) begin n_fail++; $display("FAIL both_discard_outs: got %b expected 11", {left_n, right_n}); end
        key_left_n = 1'b0;
        ticks(10);
        key_left_n = 1'b1;
        ticks(10);
        to_boundary();
        n_cmp++; if ({left_n, right_n} !== 2'b01) begin n_fail++; $display("FAIL both_cleared_left_only: got %b expected 01", {left_n, right_n}); end
        key_right_n = 1'b0;
        ticks(10);
        key_right_n = 1'b1;
        ticks(10);
        to_boundary();
        n_cmp++; if ({left_n, right_n} !== 2'b10) begin n_fail++; $display("FAIL right_only_outs: got %b expected 10", {left_n, right_n}); end
        to_boundary();
        n_cmp++; if ({left_n, right_n} !== 2'b11) begin n_fail++; $display("FAIL right_only_after_outs: got %b expected 11", {left_n, right_n}); end
    endtask

    task automatic test_autorepeat();
        logic [12:0] exp_low;
`ifdef PLATE_AUTOREPEAT_EN
        exp_low = 13'b0_0101_0101_0010;
`else
        exp_low = 13'b0_0000_0000_0010;
`endif
        do_reset();
        key_left_n = 1'b0;
        for (int f = 1; f <= 12; f++) begin
            to_boundary();
            if (f == 9) key_left_n = 1'b1;
            n_cmp++;
            if (left_n !== ~exp_low[f]) begin
                n_fail++;
                $display("FAIL hold_frame%0d_left_n: got %b expected %b", f, left_n, ~exp_low[f]);
            end
        end
    endtask

    task automatic test_two_presses();
        do_reset();
        key_left_n = 1'b0;
        ticks(10);
        key_left_n = 1'b1;
        ticks(10);
        n_cmp++; if (held !== 2'b00) begin n_fail++; $display("FAIL two_press_gap_held: got %b expected 00", held); end
        key_left_n = 1'b0;
        ticks(10);
        n_cmp++; if (held !== 2'b10) begin n_fail++; $display("FAIL two_press_second_held: got %b expected 10", held); end
        key_left_n = 1'b1;
        ticks(10);
        to_boundary();
        n_cmp++; if (left_n !== 1'b0) begin n_fail++; $display("FAIL two_press_armed_left_n: got %b expected 0", left_n); end
        to_boundary();
        n_cmp++; if (left_n !== 1'b1) begin n_fail++; $display("FAIL two_press_single_frame_left_n: got %b expected 1", left_n); end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        resetn      = 1'b0;
        key_left_n  = 1'b1;
        key_right_n = 1'b1;
        draw_done   = 1'b0;
        test_reset();
        test_debounce();
        test_press_at_boundary();
        test_both_pending();
        test_autorepeat();
        test_two_presses();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
